// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the data bus bridge: FSM state encoding,
// default window bases and bus-error classification codes.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_RD,
    MMIO,
    DONE
  } busStateT;

  localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h10010000;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFF200000;

  localparam logic [1:0] BERR_NONE     = 2'd0;
  localparam logic [1:0] BERR_UNMAPPED = 2'd1;
  localparam logic [1:0] BERR_CONFLICT = 2'd2;
  localparam logic [1:0] BERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational region select for the data bus: RAM window, MMIO page or
// unmapped, plus the RAM word offset relative to the window base.
module bus_addr_decoder
  import riscv_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic [31:0]       address,
  output logic              isRam,
  output logic              isMmio,
  output logic [RAM_AW-1:0] ramWordAddr
);

  logic [31:0] ramOffset;

  // Unsigned subtraction wraps addresses below the base to huge offsets,
  // so the single upper-bits check rejects both sides of the window.
  always_comb begin
    ramOffset   = address - RAM_BASE;
    isRam       = (ramOffset >> (RAM_AW + 2)) == 32'd0;
    isMmio      = address[31:8] == MMIO_BASE[31:8];
    ramWordAddr = ramOffset[RAM_AW+1:2];
  end

endmodule

// File: rtl/data_bus_bridge.sv
// Data bus bridge between the single-cycle core and data RAM / MMIO.
// Stalls the core while a RAM load or MMIO access is outstanding.
//
// state  | meaning
// IDLE   | decode core request; RAM stores complete here with no stall
// RAM_RD | RAM read data arriving; latch it
// MMIO   | request held toward the MMIO port until ack or timeout
// DONE   | stall released; core commits the latched data this cycle
module data_bus_bridge
  import riscv_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          TIMEOUT   = 15
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iReadEnable,
  input  logic              iWriteEnable,
  input  logic [3:0]        iByteEnable,
  input  logic [31:0]       iAddress,
  input  logic [31:0]       iWriteData,
  output logic [31:0]       oReadData,
  output logic              oStall,
  output logic              oBusError,
  output logic [RAM_AW-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [3:0]        oRamBe,
  output logic [31:0]       oRamWData,
  input  logic [31:0]       iRamRData,
  output logic              oMmioReq,
  output logic              oMmioWe,
  output logic [7:0]        oMmioAddr,
  output logic [3:0]        oMmioBe,
  output logic [31:0]       oMmioWData,
  input  logic              iMmioAck,
  input  logic [31:0]       iMmioRData
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  busStateT          state;
  busStateT          stateNext;
  logic [7:0]        toCnt;
  logic [31:0]       readReg;
  logic              isRam;
  logic              isMmio;
  logic [RAM_AW-1:0] ramWordAddr;
  logic              access;
  logic              badAccess;
  logic              mmioTimeout;

  bus_addr_decoder #(
    .RAM_BASE (RAM_BASE),
    .RAM_AW   (RAM_AW),
    .MMIO_BASE(MMIO_BASE)
  ) uDecoder (
    .address    (iAddress),
    .isRam      (isRam),
    .isMmio     (isMmio),
    .ramWordAddr(ramWordAddr)
  );

  // Requests are masked while reset is held so stall drops with it.
  always_comb begin
    access      = iRST_N & (iReadEnable | iWriteEnable);
    badAccess   = (state == IDLE) & access &
                  ((iReadEnable & iWriteEnable) | (~isRam & ~isMmio));
    mmioTimeout = (state == MMIO) & ~iMmioAck & (toCnt == TO_LAST);
  end

  always_comb begin
    stateNext = state;
    oStall    = 1'b0;
    oRamWe    = 1'b0;
    oMmioReq  = 1'b0;
    case (state)
      IDLE: begin
        if (access && !badAccess) begin
          if (isRam) begin
            if (iWriteEnable) begin
              oRamWe = 1'b1;
            end else begin
              oStall    = 1'b1;
              stateNext = RAM_RD;
            end
          end else begin
            oStall    = 1'b1;
            stateNext = MMIO;
          end
        end
      end
      RAM_RD: begin
        oStall    = 1'b1;
        stateNext = DONE;
      end
      MMIO: begin
        oStall   = 1'b1;
        oMmioReq = 1'b1;
        if (iMmioAck || mmioTimeout) stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oBusError  = badAccess | mmioTimeout;
    oReadData  = badAccess ? 32'd0 : readReg;
    oRamAddr   = ramWordAddr;
    oRamBe     = iByteEnable;
    oRamWData  = iWriteData;
    oMmioWe    = iWriteEnable;
    oMmioAddr  = iAddress[7:0];
    oMmioBe    = iByteEnable;
    oMmioWData = iWriteData;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      toCnt   <= 8'd0;
      readReg <= 32'd0;
    end else begin
      state <= stateNext;
      if (state == MMIO && stateNext == MMIO) toCnt <= toCnt + 8'd1;
      else toCnt <= 8'd0;
      case (state)
        IDLE: begin
          if (badAccess) readReg <= 32'd0;
        end
        RAM_RD: readReg <= iRamRData;
        MMIO: begin
          if (iMmioAck) begin
            if (!iWriteEnable) readReg <= iMmioRData;
          end else if (mmioTimeout) begin
            readReg <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Randomized transaction-level bench for data_bus_bridge with a RAM model,
// an MMIO responder and a reference model of expected stalls/data/errors.
module tb_data_bus_bridge;

  localparam logic [31:0] RAM_BASE_C  = 32'h10010000;
  localparam logic [31:0] MMIO_BASE_C = 32'hFF200000;
  localparam int          TO          = 15;
  localparam logic [31:0] RAM_BYTES   = 32'd16384;

  logic        iCLK;
  logic        iRST_N;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oStall;
  logic        oBusError;
  logic [11:0] oRamAddr;
  logic        oRamWe;
  logic [3:0]  oRamBe;
  logic [31:0] oRamWData;
  logic [31:0] iRamRData;
  logic        oMmioReq;
  logic        oMmioWe;
  logic [7:0]  oMmioAddr;
  logic [3:0]  oMmioBe;
  logic [31:0] oMmioWData;
  logic        iMmioAck;
  logic [31:0] iMmioRData;

  int passCnt  = 0;
  int checkCnt = 0;

  logic [31:0] ramArr [0:4095];
  logic [31:0] refMem [0:4095];
  bit          refValid [0:4095];

  data_bus_bridge #(
    .RAM_BASE (RAM_BASE_C),
    .RAM_AW   (12),
    .MMIO_BASE(MMIO_BASE_C),
    .TIMEOUT  (TO)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iReadEnable (iReadEnable),
    .iWriteEnable(iWriteEnable),
    .iByteEnable (iByteEnable),
    .iAddress    (iAddress),
    .iWriteData  (iWriteData),
    .oReadData   (oReadData),
    .oStall      (oStall),
    .oBusError   (oBusError),
    .oRamAddr    (oRamAddr),
    .oRamWe      (oRamWe),
    .oRamBe      (oRamBe),
    .oRamWData   (oRamWData),
    .iRamRData   (iRamRData),
    .oMmioReq    (oMmioReq),
    .oMmioWe     (oMmioWe),
    .oMmioAddr   (oMmioAddr),
    .oMmioBe     (oMmioBe),
    .oMmioWData  (oMmioWData),
    .iMmioAck    (iMmioAck),
    .iMmioRData  (iMmioRData)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Synchronous-read data RAM
  always @(posedge iCLK) begin
    if (oRamWe)
      for (int b = 0; b < 4; b++)
        if (oRamBe[b]) ramArr[oRamAddr][8*b +: 8] <= oRamWData[8*b +: 8];
    iRamRData <= ramArr[oRamAddr];
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One core access; ackAt = req cycle on which the responder acks (0 = never).
  task automatic runAccess(input logic re, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int ackAt, input logic [31:0] ackData);
    int stallCnt = 0, reqCnt = 0, errCnt = 0, weCnt = 0;
    logic [31:0] weAddr = 0, rdata = 0;
    bit finished = 0;
    logic [31:0] off = addr - RAM_BASE_C;
    bit inRam  = off < RAM_BYTES;
    bit inMmio = (addr >= MMIO_BASE_C) && (addr - MMIO_BASE_C < 32'd256);
    bit bad    = (re && we) || !(inRam || inMmio);
    int expStall = 0, expReq = 0, expErr = 0, expWe = 0;
    logic [31:0] expData = 0;
    bit chkData = 0;

    if (bad) begin
      expErr = 1; chkData = 1; expData = 0;
    end else if (inRam && we) begin
      expWe = 1;
    end else if (inRam) begin
      expStall = 2; chkData = 1; expData = refMem[off >> 2];
    end else if (ackAt >= 1 && ackAt <= TO) begin
      expReq = ackAt; expStall = ackAt + 1;
      if (re) begin chkData = 1; expData = ackData; end
    end else begin
      expReq = TO; expStall = TO + 1; expErr = 1; chkData = 1; expData = 0;
    end

    @(negedge iCLK);
    iReadEnable = re; iWriteEnable = we; iAddress = addr;
    iByteEnable = be; iWriteData = wd;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (c > 0) @(negedge iCLK);
      if (oMmioReq) begin
        reqCnt++;
        iMmioAck   = (reqCnt == ackAt);
        iMmioRData = (reqCnt == ackAt) ? ackData : $urandom;
      end else begin
        // stray acks outside a request must be ignored
        iMmioAck   = ($urandom_range(0, 3) == 0);
        iMmioRData = $urandom;
      end
      #1;
      if (oStall) stallCnt++;
      if (oBusError) errCnt++;
      if (oRamWe) begin weCnt++; weAddr = 32'(oRamAddr); end
      if (!oStall) begin finished = 1; rdata = oReadData; end
    end

    checkVal("completes", 32'(finished), 32'd1);
    checkVal("stallCycles", stallCnt, expStall);
    checkVal("reqCycles", reqCnt, expReq);
    checkVal("busErrPulses", errCnt, expErr);
    checkVal("ramWeCycles", weCnt, expWe);
    if (expWe != 0) checkVal("ramAddr", weAddr, off >> 2);
    if (chkData) checkVal("readData", rdata, expData);

    if (!bad && inRam && we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) refMem[off >> 2][8*b +: 8] = wd[8*b +: 8];
      if (be == 4'hF) refValid[off >> 2] = 1;
    end
  endtask

  function automatic int poolWord(input int idx);
    return (idx < 8) ? idx : 4088 + idx - 8;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST_N = 1'b0; iReadEnable = 1'b0; iWriteEnable = 1'b0; iByteEnable = 4'h0;
    iAddress = 32'h0; iWriteData = 32'h0; iMmioAck = 1'b0; iMmioRData = 32'h0;
    for (int i = 0; i < 4096; i++) begin refMem[i] = 32'h0; refValid[i] = 0; end
    repeat (3) @(negedge iCLK);
    #1;
    checkVal("rstStall", 32'(oStall), 32'd0);
    checkVal("rstBusErr", 32'(oBusError), 32'd0);
    checkVal("rstReadData", oReadData, 32'd0);
    checkVal("rstRamWe", 32'(oRamWe), 32'd0);
    checkVal("rstMmioReq", 32'(oMmioReq), 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    // directed cases
    runAccess(0, 1, 32'h10010008, 4'b0011, 32'h0000BEEF, 0, 0);
    runAccess(0, 1, 32'h10010008, 4'b1111, 32'hCAFEF00D, 0, 0);
    runAccess(1, 0, 32'h10010008, 4'b1111, 32'h0, 0, 0);
    runAccess(1, 0, 32'hFF200010, 4'b1111, 32'h0, 3, 32'h00000041);
    runAccess(1, 0, 32'hFF200010, 4'b1111, 32'h0, 0, 32'h0);
    runAccess(1, 0, 32'hFF200004, 4'b1111, 32'h0, TO, 32'h12345678);
    runAccess(1, 0, 32'hFF2000FC, 4'b1111, 32'h0, 1, 32'h9ABCDEF0);
    runAccess(0, 1, 32'hFF2000FF, 4'b1000, 32'hAA000000, 2, 32'h0);
    runAccess(1, 0, 32'h00000000, 4'b1111, 32'h0, 0, 0);
    runAccess(1, 1, 32'h10010008, 4'b1111, 32'h11111111, 0, 0);
    runAccess(1, 0, 32'h1000FFFC, 4'b1111, 32'h0, 0, 0);
    runAccess(0, 1, 32'h10014000, 4'b1111, 32'h22222222, 0, 0);
    runAccess(1, 0, 32'hFF200100, 4'b1111, 32'h0, 1, 32'h0);
    runAccess(0, 1, 32'h10013FFC, 4'b1111, 32'h5A5AA5A5, 0, 0);
    runAccess(1, 0, 32'h10013FFE, 4'b1111, 32'h0, 0, 0);

    // reset during an MMIO wait
    @(negedge iCLK);
    iReadEnable = 1'b1; iWriteEnable = 1'b0; iAddress = 32'hFF200020; iMmioAck = 1'b0;
    repeat (4) @(negedge iCLK);
    #1;
    checkVal("preRstMmioReq", 32'(oMmioReq), 32'd1);
    #1 iRST_N = 1'b0;
    #1;
    checkVal("midRstMmioReq", 32'(oMmioReq), 32'd0);
    checkVal("midRstStall", 32'(oStall), 32'd0);
    checkVal("midRstReadData", oReadData, 32'd0);
    @(negedge iCLK);
    iReadEnable = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    runAccess(1, 0, 32'h10010008, 4'b1111, 32'h0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 16; i++)
      runAccess(0, 1, RAM_BASE_C + 32'(poolWord(i)) * 4, 4'hF, $urandom, 0, 0);
    for (int n = 0; n < 90; n++) begin
      int kind = $urandom_range(0, 9);
      int w    = poolWord($urandom_range(0, 15));
      logic [31:0] ramA  = RAM_BASE_C + 32'(w) * 4 + 32'($urandom_range(0, 3));
      logic [31:0] mmioA = MMIO_BASE_C + 32'($urandom_range(0, 255));
      logic [3:0]  be    = 4'($urandom_range(1, 15));
      if (kind <= 3 || (kind <= 5 && !refValid[w]))
        runAccess(0, 1, ramA, be, $urandom, 0, 0);
      else if (kind <= 5)
        runAccess(1, 0, ramA, 4'hF, 32'h0, 0, 0);
      else if (kind <= 7)
        runAccess($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'b0, mmioA, be, $urandom,
                  $urandom_range(0, TO + 1), $urandom);
      else if (kind == 8)
        runAccess(1'($urandom_range(0, 1)), 1'b1, $urandom & 32'h0FFFFFFF, be, $urandom, 0, 0);
      else
        runAccess(1, 1, $urandom_range(0, 1) == 1 ? ramA : mmioA, be, $urandom, 1, 0);
    end

    @(negedge iCLK);
    iReadEnable = 1'b0; iWriteEnable = 1'b0;
    repeat (2) @(negedge iCLK);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
